// File: rtl/cmplx_mac_engine.sv
// cmplx_mac_engine: LANES-wide complex multiply-accumulate (dot product) engine.
// One complex A operand is broadcast to every lane each beat, and each lane has its own B operand.
// Each lane accumulates sum(A*B) over k_len beats.
// Ready/valid flow control is used on both the operand side and the result side.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start, k_len        begin a dot product of k_len beats (accepted in IDLE only)
//   busy                high while not IDLE
//   in_valid/in_ready   operand beat handshake; a_re/a_im broadcast, b_re/b_im per lane
//   out_valid/out_ready result handshake; dout_re/dout_im per lane, ACC_W bits each
//   done                one-cycle pulse after the result handshake
//   sat_flag            (CMAC_SAT_EN only) sticky saturation indicator
//
// Optional build macro CMAC_SAT_EN:
//   When defined, accumulation saturates per component and the sat_flag port is added.
//   When undefined, accumulation wraps modulo 2^ACC_W.
module cmplx_mac_engine #(
    parameter int LANES = 2,
    parameter int DW    = 16,
    parameter int ACC_W = 64,
    parameter int KW    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [KW-1:0]          k_len,
    output logic                   busy,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DW-1:0]          a_re,
    input  logic [DW-1:0]          a_im,
    input  logic [LANES*DW-1:0]    b_re,
    input  logic [LANES*DW-1:0]    b_im,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*ACC_W-1:0] dout_re,
    output logic [LANES*ACC_W-1:0] dout_im,
`ifdef CMAC_SAT_EN
    output logic                   sat_flag,
`endif
    output logic                   done
);

    localparam int PW = 2 * DW;
    localparam int SW = 2 * DW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_OUTPUT
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [KW-1:0] r_klen;
    logic [KW-1:0] r_cnt;
    logic [KW-1:0] w_cnt_nxt;
    logic          r_s1_vld;
    logic          r_s2_vld;
    logic          r_done;
    logic          w_xfer;
    logic          w_hs;
    logic          w_start_ok;

    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign w_xfer     = in_valid && in_ready;
    assign w_hs       = out_valid && out_ready;
    assign w_cnt_nxt  = r_cnt + KW'(1);
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (k_len != '0) ? ST_ACCUM : ST_OUTPUT;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && (w_cnt_nxt == r_klen)) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Last beat must have left both pipeline stages.
                if (!r_s1_vld && !r_s2_vld) begin
                    w_state_nxt = ST_OUTPUT;
                end
            end
            ST_OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_klen   <= '0;
            r_cnt    <= '0;
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_s1_vld <= w_xfer;
            r_s2_vld <= r_s1_vld;
            r_done   <= w_hs;
            if (w_start_ok) begin
                r_klen <= k_len;
                r_cnt  <= '0;
            end else if (w_xfer) begin
                r_cnt <= w_cnt_nxt;
            end
        end
    end

`ifdef CMAC_SAT_EN
    // The MSB of the result is the overflow flag.
    // The low ACC_W bits are the clamped sum.
    function automatic logic [ACC_W:0] f_sat_add(
        input logic [ACC_W-1:0] a,
        input logic [ACC_W-1:0] b
    );
        logic [ACC_W:0]   s;
        logic [ACC_W-1:0] mx;
        s  = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        mx = {1'b0, {(ACC_W-1){1'b1}}};
        if (s[ACC_W] != s[ACC_W-1]) begin
            return {1'b1, (s[ACC_W] ? ~mx : mx)};
        end
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    logic [LANES-1:0] w_sat_ev;
    logic             r_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat <= 1'b0;
        end else if (w_start_ok) begin
            r_sat <= 1'b0;
        end else if (|w_sat_ev) begin
            r_sat <= 1'b1;
        end
    end

    assign sat_flag = r_sat;
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [DW-1:0]    w_br;
        logic signed [DW-1:0]    w_bi;
        logic signed [PW-1:0]    r_pp_rr;
        logic signed [PW-1:0]    r_pp_ii;
        logic signed [PW-1:0]    r_pp_ri;
        logic signed [PW-1:0]    r_pp_ir;
        logic        [SW-1:0]    r_s2_re;
        logic        [SW-1:0]    r_s2_im;
        logic        [ACC_W-1:0] r_acc_re;
        logic        [ACC_W-1:0] r_acc_im;
        logic        [ACC_W-1:0] w_ext_re;
        logic        [ACC_W-1:0] w_ext_im;
        logic        [ACC_W-1:0] w_nxt_re;
        logic        [ACC_W-1:0] w_nxt_im;

        assign w_br = $signed(b_re[l*DW +: DW]);
        assign w_bi = $signed(b_im[l*DW +: DW]);

        assign w_ext_re = {{(ACC_W-SW){r_s2_re[SW-1]}}, r_s2_re};
        assign w_ext_im = {{(ACC_W-SW){r_s2_im[SW-1]}}, r_s2_im};

`ifdef CMAC_SAT_EN
        logic [ACC_W:0] w_add_re;
        logic [ACC_W:0] w_add_im;

        assign w_add_re = f_sat_add(r_acc_re, w_ext_re);
        assign w_add_im = f_sat_add(r_acc_im, w_ext_im);
        assign w_nxt_re = w_add_re[ACC_W-1:0];
        assign w_nxt_im = w_add_im[ACC_W-1:0];
        assign w_sat_ev[l] = r_s2_vld && (w_add_re[ACC_W] || w_add_im[ACC_W]);
`else
        assign w_nxt_re = r_acc_re + w_ext_re;
        assign w_nxt_im = r_acc_im + w_ext_im;
`endif

        always_ff @(posedge clk) begin
            if (rst) begin
                r_pp_rr  <= '0;
                r_pp_ii  <= '0;
                r_pp_ri  <= '0;
                r_pp_ir  <= '0;
                r_s2_re  <= '0;
                r_s2_im  <= '0;
                r_acc_re <= '0;
                r_acc_im <= '0;
            end else begin
                // Stage 1: products, captured only on a real transfer.
                if (w_xfer) begin
                    r_pp_rr <= PW'($signed(a_re)) * PW'(w_br);
                    r_pp_ii <= PW'($signed(a_im)) * PW'(w_bi);
                    r_pp_ri <= PW'($signed(a_re)) * PW'(w_bi);
                    r_pp_ir <= PW'($signed(a_im)) * PW'(w_br);
                end
                // Stage 2: complex combine at one extra bit.
                if (r_s1_vld) begin
                    r_s2_re <= {r_pp_rr[PW-1], r_pp_rr}
                             - {r_pp_ii[PW-1], r_pp_ii};
                    r_s2_im <= {r_pp_ri[PW-1], r_pp_ri}
                             + {r_pp_ir[PW-1], r_pp_ir};
                end
                if (w_start_ok) begin
                    r_acc_re <= '0;
                    r_acc_im <= '0;
                end else if (r_s2_vld) begin
                    r_acc_re <= w_nxt_re;
                    r_acc_im <= w_nxt_im;
                end
            end
        end

        assign dout_re[l*ACC_W +: ACC_W] = r_acc_re;
        assign dout_im[l*ACC_W +: ACC_W] = r_acc_im;
    end

endmodule

// File: tb/tb_cmplx_mac_engine.sv
// tb_cmplx_mac_engine: scoreboard bench for cmplx_mac_engine.
// The reference model does plain integer complex arithmetic per beat.
module tb_cmplx_mac_engine;

    localparam int LANES = 2;
    localparam int DW    = 16;
`ifdef CMAC_SAT_EN
    localparam int ACC_W = 34;
`else
    localparam int ACC_W = 64;
`endif
    localparam int KW = 16;
    localparam int BW = LANES * DW;
    localparam int OW = LANES * ACC_W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [KW-1:0] k_len = '0;
    logic          busy;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a_re = '0;
    logic [DW-1:0] a_im = '0;
    logic [BW-1:0] b_re = '0;
    logic [BW-1:0] b_im = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] dout_re;
    logic [OW-1:0] dout_im;
    logic          done;
`ifdef CMAC_SAT_EN
    logic          sat_flag;
`endif

    always #5 clk = ~clk;

    cmplx_mac_engine #(
        .LANES(LANES), .DW(DW), .ACC_W(ACC_W), .KW(KW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout_re(dout_re), .dout_im(dout_im),
`ifdef CMAC_SAT_EN
        .sat_flag(sat_flag),
`endif
        .done(done)
    );

    typedef struct packed {
        logic [OW-1:0] re;
        logic [OW-1:0] im;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   rdy_mode = 2;

    logic signed [ACC_W-1:0] m_re [LANES];
    logic signed [ACC_W-1:0] m_im [LANES];
    bit                      m_sat;

    task automatic chk(input string nm, input logic [OW-1:0] act,
                       input logic [OW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] pk2(input int l0, input int l1);
        return {DW'(l1), DW'(l0)};
    endfunction

    function automatic logic signed [ACC_W-1:0] acc_add(
        input logic signed [ACC_W-1:0] acc, input longint t);
        logic signed [ACC_W+1:0] s;
`ifdef CMAC_SAT_EN
        logic signed [ACC_W+1:0] mx;
        logic signed [ACC_W+1:0] mn;
`endif
        s = (ACC_W+2)'(acc) + (ACC_W+2)'(t);
`ifdef CMAC_SAT_EN
        mx = '0;
        mx[ACC_W-2:0] = '1;
        mn = ~mx;
        if (s > mx) begin
            s = mx;
            m_sat = 1'b1;
        end else if (s < mn) begin
            s = mn;
            m_sat = 1'b1;
        end
`endif
        return s[ACC_W-1:0];
    endfunction

    task automatic model_clear();
        for (int l = 0; l < LANES; l++) begin
            m_re[l] = '0;
            m_im[l] = '0;
        end
        m_sat = 1'b0;
    endtask

    task automatic model_beat(input logic [DW-1:0] ar, input logic [DW-1:0] ai,
                              input logic [BW-1:0] br, input logic [BW-1:0] bi);
        for (int l = 0; l < LANES; l++) begin
            logic signed [DW-1:0] sbr;
            logic signed [DW-1:0] sbi;
            longint tr;
            longint ti;
            sbr = br[l*DW +: DW];
            sbi = bi[l*DW +: DW];
            tr = longint'($signed(ar)) * longint'(sbr)
               - longint'($signed(ai)) * longint'(sbi);
            ti = longint'($signed(ar)) * longint'(sbi)
               + longint'($signed(ai)) * longint'(sbr);
            m_re[l] = acc_add(m_re[l], tr);
            m_im[l] = acc_add(m_im[l], ti);
        end
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        for (int l = 0; l < LANES; l++) begin
            e.re[l*ACC_W +: ACC_W] = m_re[l];
            e.im[l*ACC_W +: ACC_W] = m_im[l];
        end
        return e;
    endfunction

    task automatic drive_junk();
        a_re = DW'($urandom);
        a_im = DW'($urandom);
        b_re = BW'({$urandom(), $urandom()});
        b_im = BW'({$urandom(), $urandom()});
    endtask

    // vmode: 0 always valid, 1 every other cycle, 2 random gaps
    task automatic txn(input int k, input int vmode, input bit rnd,
                       input int abort_at, input bit hold,
                       input logic [DW-1:0] ar, input logic [DW-1:0] ai,
                       input logic [BW-1:0] br, input logic [BW-1:0] bi);
        exp_t e;
        int   sent;
        int   cyc;
        bit   v;
        model_clear();
        start = 1'b1;
        k_len = KW'(k);
        if (k == 0) begin
            e = model_exp();
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
        k_len = KW'($urandom);
        chk1("busy_after_start", busy, 1'b1);
        if (k == 0) begin
            chk1("ov_k0", out_valid, 1'b1);
        end else begin
            sent = 0;
            cyc  = 0;
            while (sent < k) begin
                if (abort_at >= 0 && sent == abort_at) begin
                    in_valid = 1'b0;
                    rst = 1'b1;
                    @(posedge clk); #1;
                    rst = 1'b0;
                    chk1("rst_busy", busy, 1'b0);
                    chk1("rst_ov", out_valid, 1'b0);
                    chk1("rst_in_ready", in_ready, 1'b0);
                    chk1("rst_done", done, 1'b0);
                    chk("rst_dout_re", dout_re, '0);
                    chk("rst_dout_im", dout_im, '0);
                    return;
                end
                case (vmode)
                    0:       v = 1'b1;
                    1:       v = (cyc % 2 == 0);
                    default: v = ($urandom_range(99) >= 40);
                endcase
                if (rnd || !v) begin
                    drive_junk();
                end else begin
                    a_re = ar;
                    a_im = ai;
                    b_re = br;
                    b_im = bi;
                end
                in_valid = v;
                if (v && in_ready) begin
                    model_beat(a_re, a_im, b_re, b_im);
                    sent++;
                end
                cyc++;
                @(posedge clk); #1;
                if (cyc > 1000) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL beat_timeout: sent %0d of %0d", sent, k);
                    in_valid = 1'b0;
                    return;
                end
            end
            in_valid = 1'b0;
            drive_junk();
            e = model_exp();
            sb_q.push_back(e);
            chk1("in_ready_drain", in_ready, 1'b0);
            chk1("ov_lat0", out_valid, 1'b0);
            @(posedge clk); #1;
            chk1("ov_lat1", out_valid, 1'b0);
            @(posedge clk); #1;
            chk1("ov_lat2", out_valid, 1'b0);
            @(posedge clk); #1;
            chk1("ov_lat3", out_valid, 1'b1);
        end
        if (hold) begin
            for (int c = 0; c < 10; c++) begin
                start = (c == 3);
                k_len = KW'(7);
                @(posedge clk); #1;
                chk1("hold_ov", out_valid, 1'b1);
                chk1("hold_busy", busy, 1'b1);
                chk1("hold_in_ready", in_ready, 1'b0);
            end
            start = 1'b0;
            rdy_mode = 2;
        end
        cyc = 0;
        while (busy && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk1("idle_reached", busy, 1'b0);
        chk("held_re", dout_re, e.re);
        chk("held_im", dout_im, e.im);
`ifdef CMAC_SAT_EN
        chk1("sat_flag", sat_flag, m_sat);
`endif
    endtask

    // out_ready driver
    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       out_ready = 1'($urandom_range(1));
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: pops the scoreboard on each result handshake.
    initial begin
        exp_t e;
        logic hs;
        logic p_ov;
        logic p_hs;
        logic [OW-1:0] p_re;
        logic [OW-1:0] p_im;
        p_ov = 1'b0;
        p_hs = 1'b0;
        p_re = '0;
        p_im = '0;
        forever begin
            @(negedge clk);
            hs = out_valid && out_ready && !rst;
            if (done || p_hs) chk1("done_pulse", done, p_hs);
            if (out_valid && p_ov && !p_hs) begin
                chk("stable_re", dout_re, p_re);
                chk("stable_im", dout_im, p_im);
            end
            if (hs) begin
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result: got %0h expected none", dout_re);
                end else begin
                    e = sb_q.pop_front();
                    chk("dout_re", dout_re, e.re);
                    chk("dout_im", dout_im, e.im);
                end
            end
            p_ov = out_valid;
            p_hs = hs;
            p_re = dout_re;
            p_im = dout_im;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_ov", out_valid, 1'b0);
        chk1("reset_in_ready", in_ready, 1'b0);
        chk1("reset_done", done, 1'b0);
        chk("reset_dout_re", dout_re, '0);
        chk("reset_dout_im", dout_im, '0);
        rst = 1'b0;
        @(posedge clk); #1;
        rdy_mode = 2;

        txn(1, 0, 1'b0, -1, 1'b0, DW'(3), DW'(4), pk2(1, -5), pk2(2, 0));
        txn(4, 1, 1'b0, -1, 1'b0, DW'(1), DW'(1), pk2(1, 2), pk2(-1, 0));

        rdy_mode = 1;
        txn(2, 0, 1'b1, -1, 1'b1, '0, '0, '0, '0);

        rdy_mode = 2;
        txn(0, 0, 1'b0, -1, 1'b0, '0, '0, '0, '0);

        txn(4, 0, 1'b0, 2, 1'b0, DW'(7), DW'(-9), pk2(300, -4), pk2(11, 5));
        txn(1, 0, 1'b0, -1, 1'b0, DW'(2), DW'(0), pk2(0, 0), pk2(3, 0));

        txn(8, 0, 1'b0, -1, 1'b0, DW'(-32768), DW'(-32768),
            pk2(-32768, 0), pk2(32767, 0));

        rdy_mode = 0;
        for (int t = 0; t < 20; t++) begin
            txn($urandom_range(6), 2, 1'b1, -1, 1'b0, '0, '0, '0, '0);
        end

        rdy_mode = 2;
        repeat (5) @(posedge clk);
        #1;
        chk1("scoreboard_empty", (sb_q.size() == 0), 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
